// File: rtl/conv_tap_accumulator.sv
// Sums KERNEL_TAPS signed products per window, normalises by NORM_SHIFT and emits an 8-bit pixel.
// Define CONV_ACC_CLAMP_EN to saturate the pixel to 0..255 instead of wrapping to the low byte.
module conv_tap_accumulator #(
  parameter int KERNEL_TAPS = 9,
  parameter int PROD_WIDTH  = 32,
  parameter int ACC_WIDTH   = 40,
  parameter int NORM_SHIFT  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic signed [PROD_WIDTH-1:0]   prod_in,
  input  logic                           prod_valid,
  output logic                           prod_ready,
  output logic [7:0]                     pix_out,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [$clog2(KERNEL_TAPS)-1:0] tap_idx,
  output logic [31:0]                    pix_count
);

  localparam int IDX_W = $clog2(KERNEL_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'(255);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                       state, state_next;
  logic signed [ACC_WIDTH-1:0]  acc_p0, acc_next, sum;
  logic [IDX_W-1:0]             tap_next;
  logic [7:0]                   pix_next;
  logic                         accept, last_tap, load_pix, handshake;

  function automatic logic [7:0] fmt_pix(input logic signed [ACC_WIDTH-1:0] x);
`ifdef CONV_ACC_CLAMP_EN
    if (x[ACC_WIDTH-1])  return 8'h00;
    if (x > PIX_MAX)     return 8'hFF;
    return x[7:0];
`else
    return x[7:0];
`endif
  endfunction

  assign prod_ready = !pix_valid || pix_ready;
  assign accept     = prod_valid && prod_ready;
  assign handshake  = pix_valid && pix_ready;
  assign last_tap   = (tap_idx == LAST_IDX);
  assign sum        = acc_p0 + ACC_WIDTH'(prod_in);
  assign pix_next   = fmt_pix(sum >>> NORM_SHIFT);

  always_comb begin
    state_next = state;
    acc_next   = acc_p0;
    tap_next   = tap_idx;
    load_pix   = 1'b0;
    case (state)
      IDLE:    if (accept && !flush) state_next = ACCUM;
      ACCUM:   if (flush || (accept && last_tap)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Flush outranks a last-tap accept: the window is dropped and no pixel loads.
    if (flush) begin
      acc_next = '0;
      tap_next = '0;
    end else if (accept) begin
      if (last_tap) begin
        acc_next = '0;
        tap_next = '0;
        load_pix = 1'b1;
      end else begin
        acc_next = sum;
        tap_next = tap_idx + IDX_W'(1);
      end
    end
  end

  // stage p0: window accumulator and tap counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc_p0  <= '0;
      tap_idx <= '0;
    end else begin
      state   <= state_next;
      acc_p0  <= acc_next;
      tap_idx <= tap_next;
    end
  end

  // stage p1: single output register, held until the downstream takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_out   <= 8'h00;
      pix_valid <= 1'b0;
      pix_count <= 32'd0;
    end else begin
      if (handshake) pix_count <= pix_count + 32'd1;
      if (load_pix) begin
        pix_valid <= 1'b1;
        pix_out   <= pix_next;
      end else if (handshake) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_tap_accumulator.sv
// Randomised and directed bench for conv_tap_accumulator; two instances (shift 0 and shift 4)
// share the stimulus and are checked against a window-sum reference model.
module tb_conv_tap_accumulator;

  localparam int K = 9;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic signed [31:0] prod_in;
  logic               prod_valid;
  logic               pix_ready;
  logic               prod_ready0, prod_ready4;
  logic [7:0]         pix_out0, pix_out4;
  logic               pix_valid0, pix_valid4;
  logic [3:0]         tap_idx0, tap_idx4;
  logic [31:0]        pix_count0, pix_count4;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: sum of accepted products since the window opened
  longint     m_partial;
  int         m_taps;
  bit         m_valid;
  logic [7:0] m_pix0, m_pix4;
  int         m_count;

  always #5 clk = ~clk;

  conv_tap_accumulator #(.KERNEL_TAPS(K), .PROD_WIDTH(32), .ACC_WIDTH(40), .NORM_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready0), .pix_out(pix_out0), .pix_valid(pix_valid0), .pix_ready(pix_ready),
    .tap_idx(tap_idx0), .pix_count(pix_count0));

  conv_tap_accumulator #(.KERNEL_TAPS(K), .PROD_WIDTH(32), .ACC_WIDTH(40), .NORM_SHIFT(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready4), .pix_out(pix_out4), .pix_valid(pix_valid4), .pix_ready(pix_ready),
    .tap_idx(tap_idx4), .pix_count(pix_count4));

  function automatic logic [7:0] ref_pix(input longint s);
`ifdef CONV_ACC_CLAMP_EN
    if (s < 0)   return 8'h00;
    if (s > 255) return 8'hFF;
`endif
    return s[7:0];
  endfunction

  function automatic void model_clear();
    m_partial = 0;
    m_taps    = 0;
    m_valid   = 0;
    m_pix0    = 8'h00;
    m_pix4    = 8'h00;
    m_count   = 0;
  endfunction

  // drive one cycle of inputs and advance the model by the same cycle
  task automatic step(input logic v, input logic signed [31:0] d, input logic f, input logic r);
    bit rdy, acc;
    prod_valid = v;
    prod_in    = d;
    flush      = f;
    pix_ready  = r;
    @(negedge clk);
    rdy = !m_valid || r;
    acc = v && rdy;
    if (m_valid && r) begin
      m_count++;
      m_valid = 0;
    end
    if (f) begin
      m_partial = 0;
      m_taps    = 0;
    end else if (acc) begin
      m_partial += longint'(d);
      m_taps++;
      if (m_taps == K) begin
        m_valid   = 1;
        m_pix0    = ref_pix(m_partial);
        m_pix4    = ref_pix(m_partial >>> 4);
        m_partial = 0;
        m_taps    = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    if (m_valid) step(1'b0, 32'sd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    n_tests++;
    if (pix_out0 !== 8'h00 || pix_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_pix: out=%0h valid=%0b, need 0/0", pix_out0, pix_valid0);
    end
    n_tests++;
    if (tap_idx0 !== 4'd0 || pix_count0 !== 32'd0) begin
      n_fail++; $display("FAIL reset_ctr: tap=%0d count=%0d, need 0/0", tap_idx0, pix_count0);
    end
    n_tests++;
    if (prod_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %0b need 1", prod_ready0);
    end
  endtask

  task automatic test_basic_window();
    for (int i = 0; i < K - 1; i++) step(1'b1, 32'sd10, 1'b0, 1'b1);
    n_tests++;
    if (pix_valid0 !== 1'b0 || tap_idx0 !== 4'd8) begin
      n_fail++; $display("FAIL basic_pre: valid=%0b tap=%0d, need 0/8", pix_valid0, tap_idx0);
    end
    step(1'b1, 32'sd10, 1'b0, 1'b0);
    n_tests++;
    if (pix_valid0 !== 1'b1 || pix_out0 !== 8'd90) begin
      n_fail++; $display("FAIL basic_pix: valid=%0b out=%0d, need 1/90", pix_valid0, pix_out0);
    end
    n_tests++;
    if (pix_valid4 !== 1'b1 || pix_out4 !== m_pix4) begin
      n_fail++; $display("FAIL basic_pix4: valid=%0b out=%0d, need 1/%0d", pix_valid4, pix_out4, m_pix4);
    end
    step(1'b0, 32'sd0, 1'b0, 1'b1);
    n_tests++;
    if (pix_count0 !== 32'd1 || pix_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_count: count=%0d valid=%0b, need 1/0", pix_count0, pix_valid0);
    end
  endtask

  task automatic test_norm_clamp();
    int w [K] = '{16, 32, 16, 32, 64, 32, 16, 32, 16};
    logic [7:0] exp4, exp0;
`ifdef CONV_ACC_CLAMP_EN
    exp4 = 8'hFF; exp0 = 8'hFF;
`else
    exp4 = 8'h80; exp0 = 8'h00;
`endif
    for (int i = 0; i < K; i++) step(1'b1, 32'(w[i] * 200), 1'b0, 1'b1);
    n_tests++;
    if (pix_out4 !== exp4) begin
      n_fail++; $display("FAIL norm_shift4: got %0h need %0h", pix_out4, exp4);
    end
    n_tests++;
    if (pix_out0 !== exp0) begin
      n_fail++; $display("FAIL norm_shift0: got %0h need %0h", pix_out0, exp0);
    end
    drain();
  endtask

  task automatic test_negative();
    logic [7:0] exp0;
`ifdef CONV_ACC_CLAMP_EN
    exp0 = 8'h00;
`else
    exp0 = 8'hD3;
`endif
    for (int i = 0; i < K; i++) step(1'b1, -32'sd5, 1'b0, 1'b1);
    n_tests++;
    if (pix_out0 !== exp0 || pix_valid0 !== 1'b1) begin
      n_fail++; $display("FAIL negative: out=%0h valid=%0b, need %0h/1", pix_out0, pix_valid0, exp0);
    end
    n_tests++;
    if (pix_out4 !== m_pix4) begin
      n_fail++; $display("FAIL negative_shift4: got %0h need %0h", pix_out4, m_pix4);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] hold;
    for (int i = 1; i <= K; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    hold = pix_out0;
    n_tests++;
    if (hold !== 8'd45) begin
      n_fail++; $display("FAIL bp_first: got %0d need 45", hold);
    end
    for (int c = 0; c < 4; c++) begin
      prod_valid = 1'b1; prod_in = 32'sd100; pix_ready = 1'b0; flush = 1'b0;
      #1;
      n_tests++;
      if (prod_ready0 !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready: got %0b need 0", prod_ready0);
      end
      step(1'b1, 32'sd100, 1'b0, 1'b0);
      n_tests++;
      if (tap_idx0 !== 4'd0 || pix_out0 !== hold || pix_valid0 !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: tap=%0d out=%0d valid=%0b, need 0/%0d/1",
                           tap_idx0, pix_out0, pix_valid0, hold);
      end
    end
    step(1'b1, 32'sd100, 1'b0, 1'b1);
    for (int i = 1; i < K; i++) step(1'b1, 32'(i), 1'b0, 1'b1);
    n_tests++;
    if (pix_out0 !== 8'd136 || pix_count0 !== 32'(m_count)) begin
      n_fail++; $display("FAIL bp_resume: out=%0d count=%0d, need 136/%0d", pix_out0, pix_count0, m_count);
    end
    drain();
  endtask

  task automatic test_flush();
    logic [7:0] hold;
    for (int i = 0; i < 5; i++) step(1'b1, 32'sd7, 1'b0, 1'b1);
    step(1'b1, 32'sd50, 1'b1, 1'b1);
    n_tests++;
    if (tap_idx0 !== 4'd0 || pix_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL flush_idx: tap=%0d valid=%0b, need 0/0", tap_idx0, pix_valid0);
    end
    for (int i = 0; i < K; i++) step(1'b1, 32'sd1, 1'b0, 1'b1);
    n_tests++;
    if (pix_out0 !== 8'd9) begin
      n_fail++; $display("FAIL flush_next: got %0d need 9", pix_out0);
    end
    drain();
    for (int i = 0; i < K - 1; i++) step(1'b1, 32'sd1, 1'b0, 1'b0);
    step(1'b1, 32'sd1, 1'b1, 1'b0);
    n_tests++;
    if (pix_valid0 !== 1'b0 || tap_idx0 !== 4'd0) begin
      n_fail++; $display("FAIL flush_last: valid=%0b tap=%0d, need 0/0", pix_valid0, tap_idx0);
    end
    for (int i = 0; i < K; i++) step(1'b1, 32'sd3, 1'b0, 1'b0);
    hold = pix_out0;
    step(1'b0, 32'sd0, 1'b1, 1'b0);
    n_tests++;
    if (pix_valid0 !== 1'b1 || pix_out0 !== hold || hold !== 8'd27) begin
      n_fail++; $display("FAIL flush_keep: valid=%0b out=%0d, need 1/27", pix_valid0, pix_out0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int count_before;
    for (int i = 0; i < K; i++) step(1'b1, 32'sd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'sd2, 1'b0, 1'b1);
    count_before = int'(pix_count0);
    n_tests++;
    if (count_before == 0 || tap_idx0 === 4'd0) begin
      n_fail++; $display("FAIL rmid_pre: count=%0d tap=%0d, need nonzero", count_before, tap_idx0);
    end
    prod_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (pix_out0 !== 8'h00 || pix_valid0 !== 1'b0 || tap_idx0 !== 4'd0 || pix_count0 !== 32'd0) begin
      n_fail++; $display("FAIL rmid_async: out=%0h valid=%0b tap=%0d count=%0d, need all 0",
                         pix_out0, pix_valid0, tap_idx0, pix_count0);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < K; i++) step(1'b1, 32'sd3, 1'b0, 1'b1);
    n_tests++;
    if (pix_out0 !== 8'd27 || pix_valid0 !== 1'b1) begin
      n_fail++; $display("FAIL rmid_window: out=%0d valid=%0b, need 27/1", pix_out0, pix_valid0);
    end
    drain();
    n_tests++;
    if (pix_count0 !== 32'd1) begin
      n_fail++; $display("FAIL rmid_count: got %0d need 1", pix_count0);
    end
  endtask

  task automatic test_random();
    logic v, f, r;
    logic signed [31:0] d;
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 80)) - 32'sd20 : $signed($urandom());
      prod_valid = v; prod_in = d; flush = f; pix_ready = r;
      #1;
      n_tests++;
      if (prod_ready0 !== (!m_valid || r) || prod_ready4 !== prod_ready0) begin
        n_fail++; $display("FAIL rnd_ready: got %0b/%0b need %0b", prod_ready0, prod_ready4, !m_valid || r);
      end
      step(v, d, f, r);
      n_tests++;
      if (pix_valid0 !== m_valid || tap_idx0 !== m_taps[3:0] || pix_count0 !== 32'(m_count)) begin
        n_fail++; $display("FAIL rnd_ctrl: valid=%0b tap=%0d count=%0d need %0b/%0d/%0d",
                           pix_valid0, tap_idx0, pix_count0, m_valid, m_taps, m_count);
      end
      if (m_valid) begin
        n_tests++;
        if (pix_out0 !== m_pix0 || pix_out4 !== m_pix4) begin
          n_fail++; $display("FAIL rnd_pix: got %0h/%0h need %0h/%0h", pix_out0, pix_out4, m_pix0, m_pix4);
        end
      end
    end
    drain();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; prod_in = '0; prod_valid = 1'b0; pix_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_basic_window();
    test_norm_clamp();
    test_negative();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
